// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD job arbiter and its round-robin helper.
package gcd_pkg;

  localparam int unsigned GCD_W           = 16;
  localparam int unsigned GCD_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StRun,
    StResp,
    StClear
  } gcd_state_e;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin search: first valid requester after ptr, wrapping modulo N.
module gcd_rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;
  logic           hi_found;

  // Downward scan leaves the lowest index in each half; the half above ptr has priority.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[i]) begin
        if (IDW'(i) > ptr) begin
          hi_idx   = IDW'(i);
          hi_found = 1'b1;
        end else begin
          lo_idx = IDW'(i);
        end
      end
    end
  end

  assign any   = |valid;
  assign idx   = hi_found ? hi_idx : lo_idx;
  assign grant = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/gcd_job_arbiter.sv
// Shares one subtractive GCD engine among N requesters; bypasses zero operands,
// aborts on timeout and clears the engine after every engine job.
module gcd_job_arbiter
  import gcd_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = GCD_W,
  parameter int unsigned IDW     = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned TIMEOUT = GCD_TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_err,
  output logic           eng_start,
  output logic [W-1:0]   eng_data,
  output logic           eng_clr,
  input  logic           eng_done,
  input  logic [W-1:0]   eng_result,
  output logic           busy
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  gcd_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q;
  logic [W-1:0]   a_q, b_q;
  logic [CW-1:0]  cnt_q;
  logic           eng_used_q;
  logic [W-1:0]   rsp_data_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_err_q;

  logic [N-1:0]   grant;
  logic [IDW-1:0] gidx;
  logic           any;
  logic [W-1:0]   a_sel, b_sel;
  logic           accept, zero_op, timeout_hit;

  gcd_rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_rr (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  assign accept      = (state_q == StIdle) && any;
  assign zero_op     = (a_sel == '0) || (b_sel == '0);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    eng_start = 1'b0;
    eng_data  = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = grant;
        if (any) state_d = zero_op ? StResp : StLoadA;
      end
      StLoadA: begin
        eng_start = 1'b1;
        eng_data  = a_q;
        state_d   = StLoadB;
      end
      StLoadB: begin
        eng_data = b_q;
        state_d  = StRun;
      end
      StRun: begin
        eng_data = b_q;
        if (eng_done || timeout_hit) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = eng_used_q ? StClear : StIdle;
      end
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= IDW'(N - 1);
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      eng_used_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q        <= a_sel;
        b_q        <= b_sel;
        ptr_q      <= gidx;
        rsp_id_q   <= gidx;
        rsp_err_q  <= 1'b0;
        eng_used_q <= !zero_op;
        if (zero_op) rsp_data_q <= a_sel | b_sel;
      end
      if (state_q == StLoadB) cnt_q <= '0;
      if (state_q == StRun) begin
        cnt_q <= cnt_q + 1'b1;
        // Done takes priority over a coincident timeout.
        if (eng_done) begin
          rsp_data_q <= eng_result;
          rsp_err_q  <= 1'b0;
        end else if (timeout_hit) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);
  // The engine is held cleared for the whole of reset as well as after each job.
  assign eng_clr   = rst | (state_q == StClear);

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Directed bench for gcd_job_arbiter with a behavioural subtractive GCD engine attached.
module tb_gcd_job_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned W       = 16;
  localparam int unsigned IDW     = 2;
  localparam int unsigned TIMEOUT = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [IDW-1:0] rsp_id;
  logic           rsp_err;
  logic           eng_start, eng_clr, eng_done, busy;
  logic [W-1:0]   eng_data, eng_result;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_clr    = 0;

  always #5 clk = ~clk;

  gcd_job_arbiter #(
    .N       (N),
    .W       (W),
    .IDW     (IDW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_data   (eng_data),
    .eng_clr    (eng_clr),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy)
  );

  // Engine model: start loads A, next cycle loads B, then one subtraction per cycle.
  logic [W-1:0] ea, eb;
  logic [1:0]   ephase;
  logic         edone;
  logic         stall;

  always @(posedge clk) begin
    if (eng_clr) begin
      ea <= '0; eb <= '0; ephase <= 2'd0; edone <= 1'b0;
    end else if (eng_start) begin
      ea <= eng_data; ephase <= 2'd1;
    end else if (ephase == 2'd1) begin
      eb <= eng_data; ephase <= 2'd2;
    end else if (ephase == 2'd2 && !edone) begin
      if (ea == eb) edone <= 1'b1;
      else if (ea > eb) ea <= ea - eb;
      else eb <= eb - ea;
    end
  end

  assign eng_done   = edone & ~stall;
  assign eng_result = ea;

  always @(posedge clk) begin
    if (eng_start) n_start <= n_start + 1;
    if (eng_clr) n_clr <= n_clr + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic wait_rsp(input int lim, output int n);
    n = 0;
    while (!rsp_valid && n < lim) begin
      step();
      n++;
    end
    if (!rsp_valid) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; stall = 1'b0; req_a = '0; req_b = '0;
    repeat (3) step();
    n_checks++;
    if ({busy, rsp_valid, req_ready, eng_start, eng_data, rsp_data, rsp_id, rsp_err, eng_clr}
        !== {1'b0, 1'b0, 4'b0, 1'b0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_vals: got busy=%b rv=%b rr=%b st=%b ed=%0d rd=%0d id=%0d err=%b clr=%b want 0 0 0000 0 0 0 0 0 1",
                         busy, rsp_valid, req_ready, eng_start, eng_data, rsp_data, rsp_id, rsp_err, eng_clr);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (eng_clr !== 1'b0) begin n_fail++; $display("FAIL reset_release_clr: got %b want 0", eng_clr); end
  endtask

  task automatic test_round_robin();
    int exp_d[5];
    int exp_id[5];
    int n, s0, c0;
    exp_d = '{6, 1, 25, 9, 6};
    exp_id = '{0, 1, 2, 3, 0};
    s0 = n_start; c0 = n_clr;
    set_req(0, 48, 18); set_req(1, 17, 5); set_req(2, 100, 75); set_req(3, 9, 9);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first_grant: got %b want 0001", req_ready); end
    for (int j = 0; j < 5; j++) begin
      wait_rsp(40, n);
      n_checks++;
      if (n < 0) begin n_fail++; $display("FAIL rr_wait job %0d: got no response want one", j); end
      n_checks++;
      if (rsp_data !== W'(exp_d[j]) || rsp_id !== IDW'(exp_id[j])) begin
        n_fail++; $display("FAIL rr_result job %0d: got data=%0d id=%0d want data=%0d id=%0d",
                           j, rsp_data, rsp_id, exp_d[j], exp_id[j]);
      end
      if (j == 4) req_valid = '0;
      step();
    end
    step();
    rsp_ready = 1'b0;
    n_checks++;
    if ((n_start - s0) != 5 || (n_clr - c0) != 5) begin
      n_fail++; $display("FAIL rr_pulses: got start=%0d clr=%0d want 5 5", n_start - s0, n_clr - c0);
    end
  endtask

  task automatic test_single();
    int n, s0, c0;
    s0 = n_start; c0 = n_clr;
    set_req(0, 36, 24); req_valid = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    step();
    req_valid = '0; set_req(0, 16'hdead, 16'hbeef);
    #1;
    n_checks++;
    if (eng_start !== 1'b1 || eng_data !== 16'd36) begin
      n_fail++; $display("FAIL single_load_a: got start=%b data=%0d want 1 36", eng_start, eng_data);
    end
    step();
    n_checks++;
    if (eng_start !== 1'b0 || eng_data !== 16'd24) begin
      n_fail++; $display("FAIL single_load_b: got start=%b data=%0d want 0 24", eng_start, eng_data);
    end
    step();
    wait_rsp(40, n);
    n_checks++;
    if (n != 4) begin n_fail++; $display("FAIL single_latency: got %0d want 4", n); end
    n_checks++;
    if (rsp_data !== 16'd12 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp: got data=%0d id=%0d err=%b want 12 0 0", rsp_data, rsp_id, rsp_err);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_checks++;
    if (eng_clr !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_clear: got clr=%b rv=%b want 1 0", eng_clr, rsp_valid);
    end
    step();
    n_checks++;
    if (eng_clr !== 1'b0 || busy !== 1'b0 || (n_start - s0) != 1 || (n_clr - c0) != 1) begin
      n_fail++; $display("FAIL single_after: got clr=%b busy=%b starts=%0d clrs=%0d want 0 0 1 1",
                         eng_clr, busy, n_start - s0, n_clr - c0);
    end
  endtask

  task automatic test_bypass();
    int s0, c0;
    s0 = n_start; c0 = n_clr;
    set_req(2, 0, 7); req_valid = 4'b0100;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bypass_grant: got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'd7 || rsp_id !== 2'd2 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL bypass_rsp: got rv=%b data=%0d id=%0d err=%b want 1 7 2 0",
                         rsp_valid, rsp_data, rsp_id, rsp_err);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bypass_idle: got busy=%b want 0", busy); end
    set_req(2, 0, 0); req_valid = 4'b0100;
    step();
    req_valid = '0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'd0) begin
      n_fail++; $display("FAIL bypass_zero: got rv=%b data=%0d want 1 0", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || (n_start - s0) != 0 || (n_clr - c0) != 0) begin
      n_fail++; $display("FAIL bypass_no_engine: got busy=%b starts=%0d clrs=%0d want 0 0 0",
                         busy, n_start - s0, n_clr - c0);
    end
  endtask

  task automatic test_backpressure();
    int n;
    set_req(3, 100, 75); set_req(0, 5, 5); req_valid = 4'b1001;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
    step();
    req_valid = 4'b0001;
    wait_rsp(40, n);
    n_checks++;
    if (n != 7) begin n_fail++; $display("FAIL bp_latency: got %0d want 7", n); end
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if ({rsp_valid, rsp_data, rsp_id, rsp_err, req_ready} !== {1'b1, 16'd25, 2'd3, 1'b0, 4'b0}) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: got rv=%b data=%0d id=%0d err=%b rr=%b want 1 25 3 0 0000",
                           k, rsp_valid, rsp_data, rsp_id, rsp_err, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || eng_clr !== 1'b1 || req_ready !== 4'b0) begin
      n_fail++; $display("FAIL bp_accept: got rv=%b clr=%b rr=%b want 0 1 0000", rsp_valid, eng_clr, req_ready);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_timeout();
    int n;
    stall = 1'b1;
    set_req(1, 15, 10); req_valid = 4'b0010;
    step();
    req_valid = '0;
    wait_rsp(40, n);
    n_checks++;
    if (n != 10) begin n_fail++; $display("FAIL to_latency: got %0d want 10", n); end
    n_checks++;
    if (rsp_err !== 1'b1 || rsp_data !== 16'd0 || rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL to_rsp: got err=%b data=%0d id=%0d want 1 0 1", rsp_err, rsp_data, rsp_id);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    stall = 1'b0;
    n_checks++;
    if (eng_clr !== 1'b1) begin n_fail++; $display("FAIL to_clear: got %b want 1", eng_clr); end
    step();
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    wait_rsp(40, n);
    n_checks++;
    if (n < 0 || rsp_data !== 16'd5 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL to_next_job: got wait=%0d data=%0d err=%b want data 5 err 0", n, rsp_data, rsp_err);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic seen;
    set_req(0, 1000, 1); req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (4) step();
    n_checks++;
    if (busy !== 1'b1 || eng_data !== 16'd1) begin
      n_fail++; $display("FAIL mid_run_state: got busy=%b data=%0d want 1 1", busy, eng_data);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, rsp_valid, req_ready, eng_start, eng_data, rsp_data, rsp_id, rsp_err, eng_clr}
        !== {1'b0, 1'b0, 4'b0, 1'b0, 16'd0, 16'd0, 2'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL mid_run_reset: got busy=%b rv=%b rr=%b st=%b ed=%0d rd=%0d id=%0d err=%b clr=%b want 0 0 0000 0 0 0 0 0 1",
                         busy, rsp_valid, req_ready, eng_start, eng_data, rsp_data, rsp_id, rsp_err, eng_clr);
    end
    step(); step();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rsp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_run_no_rsp: got rsp_valid=1 want 0"); end
    set_req(1, 21, 14); req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_run_regrant: got %b want 0010", req_ready); end
    step();
    req_valid = '0;
    wait_rsp(40, n);
    n_checks++;
    if (n < 0 || rsp_data !== 16'd7 || rsp_id !== 2'd1 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_run_after: got wait=%0d data=%0d id=%0d err=%b want 7 1 0",
                         n, rsp_data, rsp_id, rsp_err);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_bypass();
    test_backpressure();
    test_timeout();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_job_arbiter.md
Name: gcd_job_arbiter

Overview:
Shares one GCD engine (the existing datapath plus controller pair) among N requesters. Each requester submits an operand pair over a valid/ready handshake. The block grants requesters round-robin, sequences the engine (start, then A, then B, then wait for done), and returns the result tagged with the requester id. It bypasses the engine for zero operands, because the subtractive engine never terminates on a zero. It also enforces a timeout, and pulses an engine clear after each job, because the engine holds its done state until it is cleared.

Parameters:
N, 4, number of requesters (2..16)
W, 16, operand/result width
IDW, $clog2(N), requester id width (minimum 1)
TIMEOUT, 1024, maximum cycles spent in RUN before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  N  per-requester request valid
req_ready  out  N  per-requester accept, one-hot or zero
req_a  in  N*W  operand A, requester i at bits [i*W +: W]
req_b  in  N*W  operand B, same packing
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_data  out  W  GCD result
rsp_id  out  IDW  id of the requester that owns rsp_data
rsp_err  out  1  1 = job aborted by timeout
eng_start  out  1  engine start strobe
eng_data  out  W  engine data_in
eng_clr  out  1  engine clear/restart
eng_done  in  1  engine done (level, held high once reached)
eng_result  in  W  engine A register output
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: the block is asynchronous and active-high; it uses one clock, clk, and one reset, rst.
- Reset values: state=IDLE; req_ready=0; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_err=0; eng_start=0; eng_data=0; busy=0; rr pointer=N-1, so requester 0 wins first.
- eng_clr = rst OR (state==CLEAR), so the engine is flushed during reset.
- States: IDLE, LOAD_A, LOAD_B, RUN, RESP, CLEAR.
- IDLE arbitration:
  - Winner g is the first i with req_valid[i]=1, searching from ptr+1 modulo N.
  - req_ready[g]=1 combinationally, in IDLE only.
  - On transfer (valid & ready): latch a, b and id=g; set ptr<=g.
  - If a==0 or b==0: go to RESP with rsp_data = a|b (gcd(0,0)=0), rsp_err=0, eng_used=0.
  - Otherwise: go to LOAD_A with eng_used=1.
  - If no request is valid, stay in IDLE.
- LOAD_A: eng_start=1, eng_data=a, then go to LOAD_B.
- LOAD_B: eng_start=0, eng_data=b, then go to RUN.
- RUN:
  - eng_data is held at b; the timeout counter increments from 0.
  - First cycle with eng_done=1: rsp_data<=eng_result, rsp_err<=0, go to RESP.
  - Counter reaches TIMEOUT-1 with eng_done=0: rsp_data<=0, rsp_err<=1, go to RESP.
  - eng_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable until rsp_ready=1.
  - On handshake, go to CLEAR if eng_used, else IDLE.
  - rsp_ready is ignored outside RESP.
- CLEAR: eng_clr=1 for exactly one cycle, then go to IDLE. No grant is issued in CLEAR.
- Latency (accept at cycle T):
  - Bypass: rsp_valid at T+1.
  - Engine job: eng_start at T+1; RUN entered at T+3; rsp_valid one cycle after eng_done is first seen.
- Single job in flight; there is no queueing. Requesters not granted wait with valid held.
- Requester inputs are sampled only on the transfer cycle; a later change is ignored.
- Reset asserted mid-job: the job is dropped, no response is produced, and the engine is cleared.

Decomposition:
- Shared package gcd_pkg holds:
  - the state encoding typedef (IDLE..CLEAR);
  - default widths GCD_W=16;
  - GCD_TIMEOUT_DEF=1024.
- One sub-module, gcd_rr_arbiter, holds the combinational round-robin search (inputs: valid vector and pointer; output: one-hot grant plus encoded index). The pointer register stays in the top level.

Test Plan:
- Single job: req0 a=36, b=24, with the real engine attached -> eng_start one cycle at T+1, eng_data 36 then 24; response rsp_data=12, rsp_id=0, rsp_err=0; one eng_clr pulse after the handshake.
- Round-robin: req_valid=4'b1111 held, pairs (48,18), (17,5), (100,75), (9,9) -> results 6, 1, 25, 9 returned in order with ids 0, 1, 2, 3, then requester 0 again. No requester is granted twice before the others are served.
- Bypass: req2 a=0, b=7 -> rsp_valid at T+1, rsp_data=7, rsp_id=2. Then (0,0) -> rsp_data=0. eng_start and eng_clr never pulse in either case.
- Timeout: engine stub with eng_done tied 0, TIMEOUT=8 -> rsp_err=1, rsp_data=0 after 8 RUN cycles, then one eng_clr pulse. A subsequent normal job (15,10) -> 5.
- Backpressure: rsp_ready=0 for 20 cycles during RESP -> rsp_valid, rsp_data, rsp_id and rsp_err stay stable, req_ready stays 0, and the response is accepted the cycle rsp_ready rises.
- Reset mid-RUN: assert rst during job (1000,1) -> all outputs go to reset values, eng_clr=1 during reset, no response is produced. After release, a request from req1 alone is granted and returns its correct result.
